// File: rtl/p_mul_arbiter_pkg.sv
// p_mul_arbiter_pkg: shared FSM state encodings and pack-width codes for the p_mul arbiter
package p_mul_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;
  function automatic logic pw_legal(input logic [4:0] pw);
    return (pw == PW_32) || (pw == PW_16);
  endfunction
endpackage

// File: rtl/p_mul_rr_arb.sv
// p_mul_rr_arb: combinational round-robin picker, first valid request at or after i_ptr
//   i_req   : per-requester valid
//   i_ptr   : round-robin start index (register lives in the parent)
//   o_grant : one-hot grant, zero when nothing is requested
//   o_idx   : encoded index of the granted requester
module p_mul_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);
  logic [NREQ-1:0] w_rot;
  logic w_any;
  // rotate so bit 0 is the requester at i_ptr; the lowest set bit then wins
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);
  always_comb begin
    o_idx = '0;
    w_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_idx = IDW'((32'(i_ptr) + 32'(k)) % NREQ);
        w_any = 1'b1;
      end
    end
  end
  assign o_grant = w_any ? NREQ'(1) << o_idx : '0;
endmodule

// File: rtl/p_mul_arbiter.sv
// p_mul_arbiter: round-robin front end sharing one p_mul multiplier between NREQ requesters
//   i_clock/i_reset/i_flush : clock, async active-high reset, synchronous abort
//   i_req_* / o_req_ready   : per-requester op, pack width and operands; one-hot grant
//   o_rsp_* / i_rsp_ready   : buffered response with requester id, error flag and data
//   o_mul_* / i_mul_*       : registered operands and valid/ready handshake to the multiplier
module p_mul_arbiter
  import p_mul_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = 2,
  parameter int WDOG_MAX = 40
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ-1:0]   i_req_mul_l,
  input  logic [NREQ-1:0]   i_req_mul_h,
  input  logic [NREQ-1:0]   i_req_clmul,
  input  logic [5*NREQ-1:0] i_req_pw,
  input  logic [32*NREQ-1:0] i_req_crs1,
  input  logic [32*NREQ-1:0] i_req_crs2,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_rsp_err,
  output logic [31:0]       o_rsp_data,
  output logic              o_mul_valid,
  input  logic              i_mul_ready,
  output logic              o_mul_l,
  output logic              o_mul_h,
  output logic              o_clmul,
  output logic [4:0]        o_mul_pw,
  output logic [31:0]       o_mul_crs1,
  output logic [31:0]       o_mul_crs2,
  input  logic [31:0]       i_mul_result
);
  localparam int WDW = $clog2(WDOG_MAX + 1);
  state_t r_state;
  logic [IDW-1:0] r_ptr, r_id;
  logic r_mul_l, r_mul_h, r_clmul, r_mul_valid, r_rsp_valid, r_rsp_err;
  logic [4:0] r_pw;
  logic [31:0] r_crs1, r_crs2, r_rsp_data;
  logic [WDW-1:0] r_wdog;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0] w_idx, w_ptr_nxt;
  logic w_l, w_h, w_c;
  logic [4:0] w_pw;
  logic [31:0] w_crs1, w_crs2;

  p_mul_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  // one-hot grant turns the operand select into a plain AND-OR mux
  always_comb begin
    w_l = 1'b0;
    w_h = 1'b0;
    w_c = 1'b0;
    w_pw = '0;
    w_crs1 = '0;
    w_crs2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_l = w_l | (w_grant[k] & i_req_mul_l[k]);
      w_h = w_h | (w_grant[k] & i_req_mul_h[k]);
      w_c = w_c | (w_grant[k] & i_req_clmul[k]);
      w_pw = w_pw | (w_grant[k] ? i_req_pw[k*5 +: 5] : 5'd0);
      w_crs1 = w_crs1 | (w_grant[k] ? i_req_crs1[k*32 +: 32] : 32'd0);
      w_crs2 = w_crs2 | (w_grant[k] ? i_req_crs2[k*32 +: 32] : 32'd0);
    end
  end

  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  // grants are only offered in IDLE and never while reset is held
  assign o_req_ready = (r_state == ST_IDLE && !i_reset) ? w_grant : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_mul_l <= 1'b0;
      r_mul_h <= 1'b0;
      r_clmul <= 1'b0;
      r_pw <= '0;
      r_crs1 <= '0;
      r_crs2 <= '0;
      r_wdog <= '0;
      r_mul_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_data <= '0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_mul_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_id <= w_idx;
            r_ptr <= w_ptr_nxt;
            r_mul_l <= w_l;
            r_mul_h <= w_h;
            r_clmul <= w_c;
            r_pw <= w_pw;
            r_crs1 <= w_crs1;
            r_crs2 <= w_crs2;
            r_wdog <= '0;
            r_rsp_err <= !pw_legal(w_pw);
            r_rsp_data <= '0;
            r_state <= pw_legal(w_pw) ? ST_RUN : ST_RESP;
            r_mul_valid <= pw_legal(w_pw);
            r_rsp_valid <= !pw_legal(w_pw);
          end
        end
        ST_RUN: begin
          // a finish in the expiry cycle still counts as success
          if (i_mul_ready || r_wdog == WDW'(WDOG_MAX - 1)) begin
            r_state <= ST_RESP;
            r_mul_valid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err <= !i_mul_ready;
            r_rsp_data <= i_mul_ready ? i_mul_result : 32'd0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mul_valid = r_mul_valid;
  assign o_mul_l = r_mul_l;
  assign o_mul_h = r_mul_h;
  assign o_clmul = r_clmul;
  assign o_mul_pw = r_pw;
  assign o_mul_crs1 = r_crs1;
  assign o_mul_crs2 = r_crs2;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id = r_id;
  assign o_rsp_err = r_rsp_err;
  assign o_rsp_data = r_rsp_data;
endmodule

// File: tb/tb_p_mul_arbiter.sv
// tb_p_mul_arbiter: scoreboard bench for p_mul_arbiter with a counting multiplier stub
module tb_p_mul_arbiter;
  localparam int NREQ = 2, IDW = 2, WDOG_MAX = 40;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic           err;
    logic [31:0]    data;
  } exp_t;
  logic clk = 1'b0, rst, flush = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready, req_mul_l = '0, req_mul_h = '0, req_clmul = '0;
  logic [5*NREQ-1:0] req_pw = '0;
  logic [32*NREQ-1:0] req_crs1 = '0, req_crs2 = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_data;
  logic mul_valid, mul_ready, mul_l, mul_h, clmul;
  logic [4:0] mul_pw;
  logic [31:0] mul_crs1, mul_crs2, mul_result;
  logic [63:0] prod;
  logic mul_en = 1'b1;
  int mcnt, cyc = 0, mv_cnt = 0, rv_cnt = 0, n_vec = 0, n_err = 0;
  int n, m0, r0;
  exp_t exp_q[$];
  exp_t e;

  p_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .WDOG_MAX(WDOG_MAX)) dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_mul_l(req_mul_l), .i_req_mul_h(req_mul_h), .i_req_clmul(req_clmul),
    .i_req_pw(req_pw), .i_req_crs1(req_crs1), .i_req_crs2(req_crs2),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
    .o_mul_valid(mul_valid), .i_mul_ready(mul_ready),
    .o_mul_l(mul_l), .o_mul_h(mul_h), .o_clmul(clmul), .o_mul_pw(mul_pw),
    .o_mul_crs1(mul_crs1), .o_mul_crs2(mul_crs2), .i_mul_result(mul_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier stub: finishes on its 33rd (pw32) or 17th (pw16) valid cycle
  always @(posedge clk or posedge rst)
    if (rst || !mul_valid || mul_ready) mcnt <= 0;
    else mcnt <= mcnt + 1;
  assign mul_ready = mul_valid && mul_en && (mcnt == ((mul_pw == 5'b00010) ? 16 : 32));
  assign prod = 64'(mul_crs1) * 64'(mul_crs2);
  assign mul_result = mul_h ? prod[63:32] : prod[31:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // monitor: counts busy cycles and scores every accepted response
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_valid) mv_cnt++;
      if (rsp_valid) rv_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: got id %0d err %0d data 0x%0h, none required", rsp_id, rsp_err, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_data", rsp_data, e.data);
        end
      end
    end
  end

  task automatic do_accept(input int k, input logic [4:0] pw, input logic [31:0] a,
                           input logic [31:0] b, output int acc);
    int t = 0;
    req_pw[k*5 +: 5] = pw;
    req_crs1[k*32 +: 32] = a;
    req_crs2[k*32 +: 32] = b;
    req_mul_l[k] = 1'b1;
    req_valid[k] = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept", 32'(req_ready[k]), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, input int lat, input string nm);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(cyc - acc), 32'(lat));
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b0;
    #1 rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mul_crs1", mul_crs1, 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    // single pw32 request on requester 0
    m0 = mv_cnt;
    do_accept(0, 5'b00001, 32'h3, 32'h5, n);
    exp_q.push_back(exp_t'{2'd0, 1'b0, 32'hF});
    chk("run_mul_valid", 32'(mul_valid), 32'd1);
    chk("run_mul_crs1", mul_crs1, 32'h3);
    chk("run_mul_crs2", mul_crs2, 32'h5);
    chk("run_mul_pw", 32'(mul_pw), 32'h1);
    wait_rsp(n, 34, "lat_pw32");
    chk("mv_cycles_pw32", 32'(mv_cnt - m0), 32'd33);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    // both requesters valid from rr_ptr=0: grants alternate
    req_pw = {5'b00001, 5'b00001};
    req_crs1 = {32'd7, 32'd3};
    req_crs2 = {32'd9, 32'd5};
    req_mul_l = 2'b11;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      @(negedge clk);
      while (req_ready == '0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("rr_grant", 32'(req_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
      exp_q.push_back((g % 2 == 0) ? exp_t'{2'd0, 1'b0, 32'hF} : exp_t'{2'd1, 1'b0, 32'h3F});
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain("rr_drain");
    @(posedge clk);
    #1;
    // unsupported pack width is answered next cycle with an error
    m0 = mv_cnt;
    do_accept(1, 5'b00100, 32'd7, 32'd9, n);
    exp_q.push_back(exp_t'{2'd1, 1'b1, 32'd0});
    wait_rsp(n, 1, "lat_illegal");
    chk("illegal_no_mul", 32'(mv_cnt - m0), 32'd0);
    @(posedge clk);
    #1;
    // watchdog expiry with a multiplier that never finishes
    mul_en = 1'b0;
    m0 = mv_cnt;
    do_accept(0, 5'b00001, 32'h3, 32'h5, n);
    exp_q.push_back(exp_t'{2'd0, 1'b1, 32'd0});
    wait_rsp(n, 41, "lat_wdog");
    chk("mv_cycles_wdog", 32'(mv_cnt - m0), 32'd40);
    mul_en = 1'b1;
    @(posedge clk);
    #1;
    // response held for 10 cycles while requester 0 waits
    rsp_ready = 1'b0;
    do_accept(1, 5'b00010, 32'd7, 32'd9, n);
    exp_q.push_back(exp_t'{2'd1, 1'b0, 32'h3F});
    wait_rsp(n, 18, "lat_pw16");
    req_pw[4:0] = 5'b01000;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_id", 32'(rsp_id), 32'd1);
      chk("hold_rsp_data", rsp_data, 32'h3F);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("resp_no_grant", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_grant", 32'(req_ready), 32'h1);
    n = cyc;
    exp_q.push_back(exp_t'{2'd0, 1'b1, 32'd0});
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(n, 1, "lat_after_hold");
    @(posedge clk);
    #1;
    // flush on the 10th RUN cycle: no response, then a clean request
    do_accept(0, 5'b00001, 32'h3, 32'h5, n);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    r0 = rv_cnt;
    @(negedge clk);
    chk("flush_mul_valid", 32'(mul_valid), 32'd0);
    chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_rsp", 32'(rv_cnt - r0), 32'd0);
    @(posedge clk);
    #1;
    do_accept(1, 5'b00001, 32'd7, 32'd9, n);
    exp_q.push_back(exp_t'{2'd1, 1'b0, 32'h3F});
    wait_rsp(n, 34, "lat_after_flush");
    @(posedge clk);
    #1;
    // reset in the middle of RUN clears outputs without a clock edge
    do_accept(0, 5'b00001, 32'h3, 32'h5, n);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("areset_mul_valid", 32'(mul_valid), 32'd0);
    chk("areset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    r0 = rv_cnt;
    repeat (40) @(negedge clk);
    chk("areset_no_rsp", 32'(rv_cnt - r0), 32'd0);
    @(posedge clk);
    #1;
    do_accept(0, 5'b00010, 32'h3, 32'h5, n);
    exp_q.push_back(exp_t'{2'd0, 1'b0, 32'hF});
    wait_rsp(n, 18, "lat_after_reset");
    drain("final_drain");
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
